// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch: reads PC and PC+1 over req/ack and streams them into the IR.
// Optional memory timeout abort is compiled in with `define FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter int unsigned                ADDR_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0]      PC_RESET       = '0,
    parameter int unsigned                TIMEOUT_CYCLES = 15
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  PCLoad,
    input  logic [ADDR_WIDTH-1:0] PCIn,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  MemRd,
    input  logic                  MemAck,
    input  logic [7:0]            MemData,
    output logic                  IRWrite,
    output logic                  IRLH,
    output logic [7:0]            IRByte,
    output logic [ADDR_WIDTH-1:0] PCOut,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Fault
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        LATCH,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TIMEOUT_LIMIT = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam int unsigned WAIT_WIDTH    = $clog2(TIMEOUT_LIMIT + 1);

    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic                  fault_q;

    assign Fault = fault_q;
`else
    assign Fault = 1'b0;
`endif

    // Bus request and status decode straight from the state, so reset drops them at once.
    assign MemRd   = (state == FETCH_LO) || (state == FETCH_HI);
    assign MemAddr = pc;
    assign PCOut   = pc;
    assign Busy    = (state != IDLE);

    // NOTE: every register here uses <= so all branches see the pre-edge state and pc.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            pc      <= PC_RESET;
            IRWrite <= 1'b0;
            IRLH    <= 1'b0;
            IRByte  <= '0;
            Done    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
            fault_q  <= 1'b0;
`endif
        end else begin
            IRWrite <= 1'b0;
            // Done is registered off the DONE state, so it trails that state by one cycle.
            Done    <= (state == DONE);

            case (state)
                IDLE, DONE: begin
                    if (PCLoad) begin
                        pc <= PCIn;
                    end
                    if (Start) begin
                        state <= FETCH_LO;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt <= '0;
                        fault_q  <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end

                FETCH_LO, FETCH_HI: begin
                    if (MemAck) begin
                        IRByte  <= MemData;
                        IRWrite <= 1'b1;
                        IRLH    <= (state == FETCH_HI);
                        pc      <= pc + 1'b1;
                        state   <= (state == FETCH_LO) ? FETCH_HI : LATCH;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_WIDTH'(TIMEOUT_LIMIT - 1)) begin
                        fault_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end

                LATCH: begin
                    state <= DONE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: wait-state memory responder, a fetch-level model
// compared every cycle, and literal expectations for each directed scenario.
module tb_fetch_sequencer;

    localparam int AW = 16;
    localparam int TO = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Start;
    logic          PCLoad;
    logic [AW-1:0] PCIn;
    logic [AW-1:0] MemAddr;
    logic          MemRd;
    logic          MemAck;
    logic [7:0]    MemData;
    logic          IRWrite;
    logic          IRLH;
    logic [7:0]    IRByte;
    logic [AW-1:0] PCOut;
    logic          Busy;
    logic          Done;
    logic          Fault;

    always #5 Clock = ~Clock;

    fetch_sequencer #(
        .ADDR_WIDTH    (AW),
        .PC_RESET      (16'h0000),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (Start),
        .PCLoad (PCLoad),
        .PCIn   (PCIn),
        .MemAddr(MemAddr),
        .MemRd  (MemRd),
        .MemAck (MemAck),
        .MemData(MemData),
        .IRWrite(IRWrite),
        .IRLH   (IRLH),
        .IRByte (IRByte),
        .PCOut  (PCOut),
        .Busy   (Busy),
        .Done   (Done),
        .Fault  (Fault)
    );

    // Byte memory with a programmable number of wait states per access.
    logic [7:0] mem [0:65535];
    int waits = 0;
    int wcnt  = 0;

    assign MemAck  = MemRd && (wcnt >= waits);
    assign MemData = mem[MemAddr];

    always @(posedge Clock) begin
        if (!MemRd || MemAck) wcnt <= 0;
        else                  wcnt <= wcnt + 1;
    end

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fetch-level model: a fetch is "two accepted bytes, then two settle cycles";
    // Done is reported on the cycle after the settle period ends.
    bit            m_fetch = 1'b0;
    int            m_nb    = 0;
    int            m_tail  = 0;
    int            m_wait  = 0;
    logic [AW-1:0] m_pc    = '0;
    bit            m_fault = 1'b0;
    bit            e_irw   = 1'b0;
    bit            e_lh    = 1'b0;
    bit            e_done  = 1'b0;
    logic [7:0]    e_byte  = '0;

    initial begin
        forever begin
            @(posedge Clock or posedge Reset);
            if (Reset) begin
                m_fetch = 1'b0; m_nb = 0; m_tail = 0; m_wait = 0; m_pc = '0; m_fault = 1'b0;
                e_irw = 1'b0; e_lh = 1'b0; e_done = 1'b0; e_byte = '0;
            end else begin
                e_irw  = 1'b0;
                e_done = 1'b0;
                if (m_fetch) begin
                    if (wcnt >= waits) begin
                        e_irw  = 1'b1;
                        e_lh   = (m_nb == 1);
                        e_byte = mem[m_pc];
                        m_pc   = m_pc + 1'b1;
                        m_nb   = m_nb + 1;
                        m_wait = 0;
                        if (m_nb == 2) begin
                            m_fetch = 1'b0;
                            m_tail  = 2;
                        end
                    end
`ifdef FETCH_TIMEOUT_EN
                    else begin
                        m_wait = m_wait + 1;
                        if (m_wait == TO) begin
                            m_fetch = 1'b0;
                            m_fault = 1'b1;
                        end
                    end
`endif
                end else if (m_tail == 2) begin
                    m_tail = 1;
                end else begin
                    if (m_tail == 1) e_done = 1'b1;
                    m_tail = 0;
                    if (PCLoad) m_pc = PCIn;
                    if (Start) begin
                        m_fetch = 1'b1;
                        m_nb    = 0;
                        m_wait  = 0;
                        m_fault = 1'b0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge Clock);
            if (chk_en) begin
                check("memrd",   MemRd,   m_fetch);
                if (m_fetch) check("memaddr", MemAddr, m_pc);
                check("pcout",   PCOut,   m_pc);
                check("busy",    Busy,    (m_fetch || m_tail != 0));
                check("irwrite", IRWrite, e_irw);
                check("irlh",    IRLH,    e_lh);
                check("irbyte",  IRByte,  e_byte);
                check("done",    Done,    e_done);
                check("fault",   Fault,   m_fault);
            end
        end
    end

    task automatic run_fetch(input bit load, input logic [AW-1:0] addr, input int w,
                             output int lat, output int nwr, output logic [7:0] lo,
                             output logic [7:0] hi, output logic [AW-1:0] a0,
                             output logic [AW-1:0] a1);
        lat = -1; nwr = 0; lo = '0; hi = '0; a1 = '0;
        @(negedge Clock);
        waits = w; Start = 1'b1; PCLoad = load; PCIn = addr;
        @(negedge Clock);
        Start = 1'b0; PCLoad = 1'b0;
        a0 = MemAddr;
        for (int n = 1; n <= 60; n++) begin
            @(negedge Clock);
            if (IRWrite) begin
                nwr++;
                if (IRLH) hi = IRByte;
                else begin
                    lo = IRByte;
                    a1 = MemAddr;
                end
            end
            if (Done) begin
                lat = n;
                break;
            end
        end
    endtask

    int            lat, nwr, dones, idle_cycles;
    bit            pl_done, seen;
    logic [7:0]    lo, hi;
    logic [AW-1:0] a0, a1;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 37 + (i >> 8));
        mem[16'h0000] = 8'h34;
        mem[16'h0001] = 8'h12;
        mem[16'hFFFF] = 8'hA5;

        Reset = 1'b1; Start = 1'b0; PCLoad = 1'b0; PCIn = '0;
        repeat (2) @(negedge Clock);
        check("rst_pc",      PCOut,   16'h0000);
        check("rst_busy",    Busy,    1'b0);
        check("rst_memrd",   MemRd,   1'b0);
        check("rst_irwrite", IRWrite, 1'b0);
        check("rst_irlh",    IRLH,    1'b0);
        check("rst_irbyte",  IRByte,  8'h00);
        check("rst_done",    Done,    1'b0);
        check("rst_fault",   Fault,   1'b0);
        Reset  = 1'b0;
        chk_en = 1'b1;

        // Zero-wait fetch from reset PC.
        run_fetch(1'b0, '0, 0, lat, nwr, lo, hi, a0, a1);
        check("zw_latency", lat,   4);
        check("zw_writes",  nwr,   2);
        check("zw_lo",      lo,    8'h34);
        check("zw_hi",      hi,    8'h12);
        check("zw_addr0",   a0,    16'h0000);
        check("zw_addr1",   a1,    16'h0001);
        check("zw_pc",      PCOut, 16'h0002);

        // Three wait states per byte.
        run_fetch(1'b0, '0, 3, lat, nwr, lo, hi, a0, a1);
        check("ws_latency", lat,   10);
        check("ws_writes",  nwr,   2);
        check("ws_addr0",   a0,    16'h0002);
        check("ws_addr1",   a1,    16'h0003);
        check("ws_pc",      PCOut, 16'h0004);

        // PCLoad alone in IDLE.
        @(negedge Clock);
        PCLoad = 1'b1; PCIn = 16'h1234;
        @(negedge Clock);
        PCLoad = 1'b0;
        check("idle_load", PCOut, 16'h1234);

        // PCLoad with Start across the top of the address space.
        run_fetch(1'b1, 16'hFFFF, 0, lat, nwr, lo, hi, a0, a1);
        check("wrap_latency", lat,   4);
        check("wrap_addr0",   a0,    16'hFFFF);
        check("wrap_addr1",   a1,    16'h0000);
        check("wrap_lo",      lo,    8'hA5);
        check("wrap_hi",      hi,    8'h34);
        check("wrap_pc",      PCOut, 16'h0001);

        // Start held high: back-to-back fetches, PCLoad in FETCH_HI ignored.
        @(negedge Clock);
        waits = 1; Start = 1'b1; PCLoad = 1'b1; PCIn = 16'h0100;
        @(negedge Clock);
        PCLoad = 1'b0;
        dones = 0; idle_cycles = 0; pl_done = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge Clock);
            if (Done) dones++;
            if (!Busy) idle_cycles++;
            if (PCLoad) PCLoad = 1'b0;
            else if (!pl_done && IRWrite && !IRLH) begin
                PCLoad = 1'b1; PCIn = 16'h5555; pl_done = 1'b1;
            end
        end
        Start = 1'b0;
        check("b2b_idle", idle_cycles, 0);
        for (int n = 0; n < 20; n++) begin
            @(negedge Clock);
            if (Done) dones++;
        end
        check("b2b_dones", dones, 6);
        check("b2b_pc",    PCOut, 16'h010C);

        // Reset between edges while in FETCH_HI.
        @(negedge Clock);
        waits = 3; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clock);
            if (IRWrite) begin
                seen = 1'b1;
                break;
            end
        end
        check("mid_seen_lo",   seen,  1'b1);
        check("mid_pre_memrd", MemRd, 1'b1);
        #2 Reset = 1'b1;
        #1;
        check("mid_memrd",   MemRd,   1'b0);
        check("mid_busy",    Busy,    1'b0);
        check("mid_irwrite", IRWrite, 1'b0);
        check("mid_pc",      PCOut,   16'h0000);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        dones = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge Clock);
            if (Done) dones++;
        end
        check("mid_no_done", dones, 0);
        check("mid_pc_after", PCOut, 16'h0000);

`ifdef FETCH_TIMEOUT_EN
        // Unanswered request aborts after TO cycles in FETCH_LO.
        @(negedge Clock);
        waits = 1000; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        lat = -1; nwr = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge Clock);
            if (IRWrite) nwr++;
            if (!Busy) begin
                lat = n;
                break;
            end
        end
        check("to_cycles", lat,   TO);
        check("to_fault",  Fault, 1'b1);
        check("to_writes", nwr,   0);
        check("to_pc",     PCOut, 16'h0000);
        @(negedge Clock);
        waits = 0; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        check("to_clear", Fault, 1'b0);
        repeat (8) @(negedge Clock);
        check("to_refetch_pc", PCOut, 16'h0002);
`endif

        repeat (2) @(negedge Clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary by %0t", $time);
        $fatal(1);
    end

endmodule
